test_runner: RTL and testbench
==============================

Name: test_runner

Overview:
- Sequencing harness that sits on the consumer side of the per-test `fail`/`finish` interface exported by self-checking test modules.
- Holds every attached test in reset, then releases them one at a time and waits for each `finish`.
- Latches each test's `fail`, or a timeout if `finish` never arrives.
- Exports aggregate `fail`/`finish` with the same semantics as a single test, so runners can be nested or driven by the simulation top.

Parameters:
- NUM_TESTS, 4: number of attached tests (1..32).
- RESET_CYCLES, 2: cycles the selected test's reset is held high before release (>=1).
- TIMEOUT, 1024: max cycles in RUN before the test is declared timed out (>=2).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE.
- test_fail  in  NUM_TESTS  per-test fail flags.
- test_finish  in  NUM_TESTS  per-test finish flags.
- test_reset  out  NUM_TESTS  per-test synchronous resets.
- cur_test  out  max(1,clog2(NUM_TESTS))  index of the test being reset or run.
- busy  out  1  high in RESET/RUN/NEXT.
- fail_mask  out  NUM_TESTS  bit i set if test i failed or timed out.
- timeout_mask  out  NUM_TESTS  bit i set if test i timed out.
- fail  out  1  OR of fail_mask, valid when finish is high; 0 before.
- finish  out  1  whole run complete.

Behaviour:
- One clock, synchronous active-high reset, registered outputs. Reset may be asserted in any state.
- Reset values:
  - state=IDLE, cur_test=0, timer=0.
  - fail_mask=0, timeout_mask=0, fail=0, finish=0, busy=0.
  - test_reset = all ones.
- States: IDLE, RESET, RUN, NEXT, DONE.
- test_reset rule: every bit except the selected test is always 1. The selected bit is 1 in IDLE/RESET/NEXT/DONE and 0 only in RUN.
- IDLE:
  - On start: cur_test<=0, timer<=0, go to RESET. Otherwise stay.
  - fail_mask and timeout_mask are cleared on start.
- RESET:
  - timer counts 0..RESET_CYCLES-1; at RESET_CYCLES-1, timer<=0 and go to RUN.
  - Worked timing (RESET_CYCLES=2): start sampled at edge k, RESET occupies cycles k+1 and k+2, test_reset[0] first reads 0 in cycle k+3.
- RUN: each cycle, sample test_finish[cur_test] and test_fail[cur_test].
  - finish=1: fail_mask[cur_test]<=test_fail[cur_test]; go to NEXT.
  - Else if timer==TIMEOUT-1: fail_mask[cur_test]<=1 and timeout_mask[cur_test]<=1; go to NEXT.
  - Else timer++.
  - finish wins over timeout in the same cycle.
  - Inputs of non-selected tests are ignored. Their finish/fail may be any value because they are held in reset.
- NEXT (one cycle; test re-enters reset, so it cannot re-trigger):
  - If cur_test==NUM_TESTS-1, go to DONE.
  - Else cur_test++, timer<=0, go to RESET.
- DONE:
  - finish<=1, fail<=|fail_mask. Both are held, along with the masks, until reset.
  - start is ignored. All test_reset bits are 1.
- start pulses outside IDLE have no effect.
- timer width: clog2(max(TIMEOUT,RESET_CYCLES))+1. The timer never wraps, because RUN exits at TIMEOUT-1.

Test Plan:
- NUM_TESTS=2; both stub tests assert finish=1, fail=0 two cycles after reset release; pulse start → finish=1, fail=0, fail_mask=2'b00, timeout_mask=2'b00. With start sampled at edge k: test_reset[0] low for cycles k+3..k+5, test_reset[1] low for cycles k+9..k+11, finish high from cycle k+13.
- Test 1 asserts fail=1 together with finish=1 → fail_mask=2'b10, timeout_mask=0, fail=1 at finish.
- TIMEOUT=8; test 0 never finishes → exactly 8 RUN cycles, then timeout_mask=2'b01, fail_mask=2'b01; test 1 still runs; finish=1, fail=1.
- Test 0 asserts finish on the same cycle timer reaches TIMEOUT-1 → timeout_mask[0]=0, fail_mask[0] equals the sampled fail value.
- Reset asserted mid-RUN of test 1 → next cycle: IDLE, test_reset all ones, masks=0, finish=0, fail=0. A new start reruns from test 0 with the expected results.
- start pulsed during RUN and again during DONE → no restart, cur_test unchanged, outputs held.

Source files
------------

// File: rtl/test_runner.sv
// Sequences a set of self-checking tests: holds them all in reset, releases one at a time,
// and latches each test's fail/timeout into aggregate masks and fail/finish flags.
module test_runner #(
    parameter int NUM_TESTS    = 4,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    localparam int IDX_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] test_fail,
    input  logic [NUM_TESTS-1:0] test_finish,
    output logic [NUM_TESTS-1:0] test_reset,
    output logic [IDX_W-1:0]     cur_test,
    output logic                 busy,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic                 fail,
    output logic                 finish
);

    localparam int TIMER_MAX = (TIMEOUT > RESET_CYCLES) ? TIMEOUT : RESET_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     curTest_q, curTest_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [NUM_TESTS-1:0] failMask_q, failMask_d;
    logic [NUM_TESTS-1:0] timeoutMask_q, timeoutMask_d;
    logic                 fail_q, fail_d;
    logic                 finish_q, finish_d;
    logic                 busy_q, busy_d;
    logic [NUM_TESTS-1:0] testReset_q, testReset_d;

    always_comb begin
        state_d       = state_q;
        curTest_d     = curTest_q;
        timer_d       = timer_q;
        failMask_d    = failMask_q;
        timeoutMask_d = timeoutMask_q;
        fail_d        = fail_q;
        finish_d      = finish_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    curTest_d     = '0;
                    timer_d       = '0;
                    failMask_d    = '0;
                    timeoutMask_d = '0;
                    state_d       = ST_RESET;
                end
            end
            ST_RESET: begin
                if (timer_q == TIMER_W'(RESET_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_RUN: begin
                // A finish seen on the last allowed cycle still counts as a normal finish
                if (test_finish[curTest_q]) begin
                    failMask_d[curTest_q] = test_fail[curTest_q];
                    state_d               = ST_NEXT;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    failMask_d[curTest_q]    = 1'b1;
                    timeoutMask_d[curTest_q] = 1'b1;
                    state_d                  = ST_NEXT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_NEXT: begin
                if (curTest_q == IDX_W'(NUM_TESTS - 1)) begin
                    finish_d = 1'b1;
                    fail_d   = |failMask_q;
                    state_d  = ST_DONE;
                end else begin
                    curTest_d = curTest_q + IDX_W'(1);
                    timer_d   = '0;
                    state_d   = ST_RESET;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d      = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_NEXT);
        testReset_d = '1;
        if (state_d == ST_RUN) begin
            testReset_d[curTest_d] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            curTest_q     <= '0;
            timer_q       <= '0;
            failMask_q    <= '0;
            timeoutMask_q <= '0;
            fail_q        <= 1'b0;
            finish_q      <= 1'b0;
            busy_q        <= 1'b0;
            testReset_q   <= '1;
        end else begin
            state_q       <= state_d;
            curTest_q     <= curTest_d;
            timer_q       <= timer_d;
            failMask_q    <= failMask_d;
            timeoutMask_q <= timeoutMask_d;
            fail_q        <= fail_d;
            finish_q      <= finish_d;
            busy_q        <= busy_d;
            testReset_q   <= testReset_d;
        end
    end

    assign test_reset   = testReset_q;
    assign cur_test     = curTest_q;
    assign busy         = busy_q;
    assign fail_mask    = failMask_q;
    assign timeout_mask = timeoutMask_q;
    assign fail         = fail_q;
    assign finish       = finish_q;

endmodule

// File: tb/tb_test_runner.sv
// Bench for test_runner: stub tests with configurable finish delay and fail value,
// checked cycle by cycle against a schedule computed from per-test run lengths.
module tb_test_runner;

    localparam int NT    = 4;
    localparam int RC    = 2;
    localparam int TO    = 8;
    localparam int NEVER = 255;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NT-1:0] test_fail;
    logic [NT-1:0] test_finish;
    logic [NT-1:0] test_reset;
    logic [1:0]    cur_test;
    logic          busy;
    logic [NT-1:0] fail_mask;
    logic [NT-1:0] timeout_mask;
    logic          fail;
    logic          finish;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int         d[NT];
        bit [NT-1:0] fv;
        bit [NT-1:0] efm;
        bit [NT-1:0] etm;
        bit          ef;
    } vec_t;

    int          finDelay[NT];
    bit [NT-1:0] failVal;
    int          cnt[NT];
    bit [NT-1:0] noiseFin;
    bit [NT-1:0] noiseFail;

    test_runner #(
        .NUM_TESTS   (NT),
        .RESET_CYCLES(RC),
        .TIMEOUT     (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .test_fail   (test_fail),
        .test_finish (test_finish),
        .test_reset  (test_reset),
        .cur_test    (cur_test),
        .busy        (busy),
        .fail_mask   (fail_mask),
        .timeout_mask(timeout_mask),
        .fail        (fail),
        .finish      (finish)
    );

    always #5 clock = ~clock;

    // Stub tests count cycles since release; tests held in reset drive random garbage
    always @(posedge clock) begin
        for (int i = 0; i < NT; i++) begin
            if (test_reset[i]) cnt[i] <= 0;
            else if (cnt[i] < 1000) cnt[i] <= cnt[i] + 1;
        end
        noiseFin  <= NT'($urandom);
        noiseFail <= NT'($urandom);
    end

    always_comb begin
        test_finish = '0;
        test_fail   = '0;
        for (int i = 0; i < NT; i++) begin
            if (test_reset[i]) begin
                test_finish[i] = noiseFin[i];
                test_fail[i]   = noiseFail[i];
            end else begin
                test_finish[i] = (finDelay[i] != NEVER) && (cnt[i] >= finDelay[i]);
                test_fail[i]   = failVal[i];
            end
        end
    end

    function automatic vec_t mkVec(input int d0, input int d1, input int d2, input int d3,
                                   input bit [NT-1:0] fv, input bit [NT-1:0] efm,
                                   input bit [NT-1:0] etm, input bit ef);
        vec_t v;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.fv = fv; v.efm = efm; v.etm = etm; v.ef = ef;
        return v;
    endfunction

    function automatic int runLen(input int d);
        return (d < TO) ? d + 1 : TO;
    endfunction

    function automatic int totalLen(input vec_t v);
        int s = 0;
        for (int i = 0; i < NT; i++) s += RC + runLen(v.d[i]) + 1;
        return s;
    endfunction

    function automatic void modelMasks(inout vec_t v);
        v.efm = '0;
        v.etm = '0;
        for (int i = 0; i < NT; i++) begin
            if (v.d[i] >= TO) begin
                v.efm[i] = 1'b1;
                v.etm[i] = 1'b1;
            end else begin
                v.efm[i] = v.fv[i];
            end
        end
        v.ef = |v.efm;
    endfunction

    // phase: 0 reset window, 1 running, 2 hand-off cycle, 3 done
    function automatic void sched(input vec_t v, input int t, output int phase, output int idx);
        int pos;
        pos   = t - 1;
        phase = 3;
        idx   = NT - 1;
        for (int i = 0; i < NT; i++) begin
            if (pos < RC) begin phase = 0; idx = i; return; end
            pos -= RC;
            if (pos < runLen(v.d[i])) begin phase = 1; idx = i; return; end
            pos -= runLen(v.d[i]);
            if (pos < 1) begin phase = 2; idx = i; return; end
            pos -= 1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " test_reset"}, 32'(test_reset), 32'hF);
        checkOutput({tag, " busy"}, 32'(busy), 32'h0);
        checkOutput({tag, " finish"}, 32'(finish), 32'h0);
        checkOutput({tag, " fail"}, 32'(fail), 32'h0);
        checkOutput({tag, " fail_mask"}, 32'(fail_mask), 32'h0);
        checkOutput({tag, " timeout_mask"}, 32'(timeout_mask), 32'h0);
        checkOutput({tag, " cur_test"}, 32'(cur_test), 32'h0);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        checkResetState("reset");
    endtask

    // Pulses start, then checks every cycle; stray start pulses at pulseAt and in DONE
    task automatic applyStimulus(input vec_t v, input int pulseAt, input int stopAt);
        int len, last, phase, idx;
        logic [NT-1:0] expTr;
        len      = totalLen(v);
        last     = (stopAt > 0) ? stopAt : len + 3;
        finDelay = v.d;
        failVal  = v.fv;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int t = 1; t <= last; t++) begin
            sched(v, t, phase, idx);
            expTr = '1;
            if (phase == 1) expTr[idx] = 1'b0;
            checkOutput($sformatf("cycle %0d", t),
                        32'({test_reset, busy, finish, fail, cur_test}),
                        32'({expTr, phase != 3, phase == 3, (phase == 3) && v.ef, 2'(idx)}));
            if (t == stopAt) return;
            start = (t == pulseAt) || (t == len + 1);
            @(posedge clock); #1;
        end
        start = 1'b0;
        checkOutput("fail_mask", 32'(fail_mask), 32'(v.efm));
        checkOutput("timeout_mask", 32'(timeout_mask), 32'(v.etm));
        checkOutput("fail", 32'(fail), 32'(v.ef));
    endtask

    vec_t tbl[8];

    initial begin
        vec_t v;
        reset = 1'b1;
        start = 1'b0;
        failVal = '0;
        for (int i = 0; i < NT; i++) finDelay[i] = NEVER;
        repeat (2) @(posedge clock);
        #1;
        applyReset();

        tbl[0] = mkVec(2, 2, 2, 2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tbl[1] = mkVec(2, 2, 2, 2, 4'b0010, 4'b0010, 4'b0000, 1'b1);
        tbl[2] = mkVec(NEVER, 2, 2, 2, 4'b0000, 4'b0001, 4'b0001, 1'b1);
        tbl[3] = mkVec(7, 2, 2, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        tbl[4] = mkVec(7, 2, 2, 2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tbl[5] = mkVec(8, 2, 2, 2, 4'b0000, 4'b0001, 4'b0001, 1'b1);
        tbl[6] = mkVec(0, 1, NEVER, 5, 4'b1001, 4'b1101, 4'b0100, 1'b1);
        tbl[7] = mkVec(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyReset();
            applyStimulus(tbl[i], 4, 0);
        end

        // Reset in the first run cycle of test 1, after test 0 has already failed
        v = mkVec(2, 2, 2, 2, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        applyReset();
        applyStimulus(v, 0, 9);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkResetState("mid-run reset");
        @(posedge clock); #1;
        checkOutput("idle hold test_reset", 32'(test_reset), 32'hF);
        checkOutput("idle hold busy", 32'(busy), 32'h0);
        applyStimulus(v, 0, 0);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NT; i++) begin
                v.d[i] = ($urandom_range(0, 9) == 9) ? NEVER : int'($urandom_range(0, 9));
            end
            v.fv = NT'($urandom);
            modelMasks(v);
            applyReset();
            applyStimulus(v, int'($urandom_range(1, 20)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
